// File: rtl/pedestrian_request.sv
// pedestrian_request: synchronises and debounces the raw pedestrian button,
// then holds a single crossing request until the traffic-light controller
// shows red. A cooldown after red falls keeps one crossing cycle from being
// claimed by more than one request.
//
// Handshake: btn is a level request, not a valid/ready pair. It rises one
// edge after an accepted press and stays high until the first edge at which
// red=1 is sampled. Nothing is queued, so at most one request is outstanding.
module pedestrian_request #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned COOLDOWN_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       red,
  output logic       btn,
  output logic       wait_led,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    SERVE = 2'd2,
    COOL  = 2'd3
  } state_t;

  localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN_CYCLES);

  logic       s1_q, s2_q;
  logic       db_q, db_d;
  logic       db_prev_q;
  logic [7:0] db_cnt_q, db_cnt_d;
  logic [7:0] cool_cnt_q, cool_cnt_d;
  state_t     state_q, state_d;
  logic       btn_q, btn_d;
  logic       wait_q, wait_d;
  logic       press;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
    end
  end

  // Debounce: accept a new level only after it differs from db for
  // DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    if (s2_q == db_q) begin
      db_cnt_d = 8'd0;
    end else if (db_cnt_q == DB_LAST) begin
      db_d     = s2_q;
      db_cnt_d = 8'd0;
    end else begin
      db_cnt_d = db_cnt_q + 8'd1;
    end
  end

  // Debounce state registers plus the one-cycle delayed level for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      db_cnt_q  <= 8'd0;
    end else begin
      db_q      <= db_d;
      db_prev_q <= db_q;
      db_cnt_q  <= db_cnt_d;
    end
  end

  // Rising edge of the debounced level; releases produce no event.
  assign press = db_q & ~db_prev_q;

  // Request FSM next state; outputs are derived from the next state so they
  // change on the same edge as the transition.
  always_comb begin
    state_d    = state_q;
    cool_cnt_d = cool_cnt_q;
    case (state_q)
      IDLE: begin
        if (press && !red) state_d = PEND;
      end
      PEND: begin
        if (red) state_d = SERVE;
      end
      SERVE: begin
        if (!red) begin
          if (COOLDOWN_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d    = COOL;
            cool_cnt_d = COOL_LOAD;
          end
        end
      end
      COOL: begin
        // Leaving when the count is 1 makes IDLE reappear exactly
        // COOLDOWN_CYCLES edges after red was seen low.
        if (cool_cnt_q <= 8'd1) begin
          state_d    = IDLE;
          cool_cnt_d = 8'd0;
        end else begin
          cool_cnt_d = cool_cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    btn_d  = (state_d == PEND);
    wait_d = (state_d == PEND);
  end

  // FSM state, cooldown counter and registered lamp/request outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cool_cnt_q <= 8'd0;
      btn_q      <= 1'b0;
      wait_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cool_cnt_q <= cool_cnt_d;
      btn_q      <= btn_d;
      wait_q     <= wait_d;
    end
  end

  assign btn       = btn_q;
  assign wait_led  = wait_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pedestrian_request.sv
// Testbench for pedestrian_request: table-driven reset/latency vectors,
// hand-written multi-cycle scenarios and a randomized run, all checked
// against a behavioural model of the request rules.
module tb_pedestrian_request;

  localparam int D    = 4;
  localparam int COOL = 8;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst, btn_raw, red;
  logic       btn, wait_led;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  pedestrian_request #(
    .DEBOUNCE_CYCLES(D),
    .COOLDOWN_CYCLES(COOL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .red      (red),
    .btn      (btn),
    .wait_led (wait_led),
    .dbg_state(dbg_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- behavioural model ----------------
  // Raw button history (last entries are the most recent edges), the s2
  // samples seen by the debouncer since the last accepted level, the
  // accepted level, and the request bookkeeping in terms of edge numbers.
  bit raw_hist[$];
  bit samp[$];
  bit m_db, m_db_prev;
  bit m_req, m_served;
  int m_edge    = 0;
  int m_idle_at = 0;

  task automatic model_step(input bit r, input bit raw, input bit rd);
    bit press, s2v, flip;
    m_edge++;
    if (r) begin
      raw_hist  = {1'b0, 1'b0};
      samp.delete();
      m_db      = 1'b0;
      m_db_prev = 1'b0;
      m_req     = 1'b0;
      m_served  = 1'b0;
      m_idle_at = m_edge;
      return;
    end
    press = m_db && !m_db_prev;
    // A request is served at the first red; the next may only be taken
    // COOL edges after red was seen low again, and never during red.
    if (m_req) begin
      if (rd) begin
        m_req    = 1'b0;
        m_served = 1'b1;
      end
    end else if (m_served) begin
      if (!rd) begin
        m_served  = 1'b0;
        m_idle_at = m_edge + COOL;
      end
    end else if (m_edge > m_idle_at && press && !rd) begin
      m_req = 1'b1;
    end
    // The debouncer sees the button two edges late; a level is accepted
    // when the last D samples all disagree with the current level.
    m_db_prev = m_db;
    raw_hist.push_back(raw);
    s2v = raw_hist[raw_hist.size() - 3];
    if (raw_hist.size() > 8) void'(raw_hist.pop_front());
    samp.push_back(s2v);
    if (samp.size() > 64) void'(samp.pop_front());
    flip = (samp.size() >= D);
    for (int i = 0; i < D; i++) begin
      if (flip && samp[samp.size() - 1 - i] == m_db) flip = 1'b0;
    end
    if (flip) begin
      m_db = ~m_db;
      samp.delete();
    end
  endtask

  // ---------------- checking ----------------
  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, m_edge);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, m_edge);
    end
  endtask

  // ---------------- driver ----------------
  // One clock: inputs applied after the falling edge, model advanced at the
  // rising edge, outputs compared at the next falling edge.
  task automatic cyc(input bit r, input bit raw, input bit rd);
    rst     = r;
    btn_raw = raw;
    red     = rd;
    @(posedge clk);
    model_step(r, raw, rd);
    @(negedge clk);
    check_bit("model_btn", btn, m_req);
    check_bit("model_wait_led", wait_led, m_req);
  endtask

  task automatic clean_reset();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  // Press, hold 15 cycles, show red, release red, then issue a clean press
  // starting press_off cycles after the edge that saw red low. Returns the
  // cycle index (from that edge) after which btn was first seen high, or -1.
  task automatic run_service(input int press_off, output int rise_t);
    clean_reset();
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0);
    check_bit("svc_btn_held", btn, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    check_bit("svc_btn_clear_at_red", btn, 1'b0);
    check_bit("svc_wait_clear_at_red", wait_led, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    rise_t = -1;
    for (int t = 0; t <= 30; t++) begin
      cyc(1'b0, (t >= press_off && t < press_off + 6), 1'b0);
      if (btn === 1'b1 && rise_t < 0) rise_t = t;
    end
  endtask

  // ---------------- table vectors ----------------
  typedef struct packed {
    logic r;
    logic raw;
    logic rd;
    logic exp_btn;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int rise, rises, highs;
    logic prev;
    int raw_hold, red_hold;
    bit raw_v, red_v, rst_v;

    // Reset held 2 cycles with the button pressed, then release reset:
    // request appears 6 edges after the first post-reset edge.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 2; i < 10; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, (i - 2 >= 6)};

    rst = 1'b1; btn_raw = 1'b0; red = 1'b0;

    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].r, tbl[i].raw, tbl[i].rd);
      check_bit("tbl_btn", btn, tbl[i].exp_btn);
      check_bit("tbl_wait_led", wait_led, tbl[i].exp_btn);
    end

    // Glitch: 3 cycles high is shorter than the debounce window.
    clean_reset();
    highs = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      if (btn !== 1'b0) highs++;
    end
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (btn !== 1'b0) highs++;
    end
    check_int("glitch_no_btn", highs, 0);

    // Bounce: toggling for 6 cycles, then steady high.
    rises = 0; rise = -1; prev = btn;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, (i % 2 == 0), 1'b0);
      if (btn === 1'b1 && prev !== 1'b1) rises++;
      prev = btn;
    end
    for (int j = 0; j < 14; j++) begin
      cyc(1'b0, 1'b1, 1'b0);
      if (btn === 1'b1 && prev !== 1'b1) begin
        rises++;
        if (rise < 0) rise = j;
      end
      prev = btn;
    end
    check_int("bounce_rise_count", rises, 1);
    check_int("bounce_rise_edge", rise, 6);

    // Full service with presses at and around the end of the cooldown.
    run_service(1, rise);
    check_int("cool_press_early", rise, -1);
    run_service(2, rise);
    check_int("cool_press_at_idle_entry_lost", rise, -1);
    run_service(3, rise);
    check_int("cool_press_after_idle", rise, 9);
    run_service(9, rise);
    check_int("cool_press_9_after_red", rise, 15);

    // Press while red: ignored and not queued.
    clean_reset();
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 1'b1);
      if (btn !== 1'b0 || wait_led !== 1'b0) highs++;
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      if (btn !== 1'b0 || wait_led !== 1'b0) highs++;
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (btn !== 1'b0 || wait_led !== 1'b0) highs++;
    end
    check_int("red_press_ignored", highs, 0);

    // Reset while a request is pending and the button stays held.
    clean_reset();
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0);
    check_bit("pend_btn_before_rst", btn, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    check_bit("pend_btn_after_rst", btn, 1'b0);
    check_bit("pend_wait_after_rst", wait_led, 1'b0);
    rise = -1;
    for (int j = 0; j < 10; j++) begin
      cyc(1'b0, 1'b1, 1'b0);
      if (btn === 1'b1 && rise < 0) rise = j;
    end
    check_int("pend_rst_rerise", rise, 6);

    // Randomized traffic against the model.
    clean_reset();
    raw_v = 1'b0; red_v = 1'b0; raw_hold = 0; red_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (raw_hold == 0) begin
        raw_v    = 1'($urandom_range(0, 1));
        raw_hold = $urandom_range(1, 8);
      end
      if (red_hold == 0) begin
        red_v    = ~red_v;
        red_hold = $urandom_range(1, 40);
      end
      rst_v = ($urandom_range(0, 499) == 0);
      cyc(rst_v, raw_v, red_v);
      raw_hold--;
      red_hold--;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pedestrian_request.md
# pedestrian_request

Conditions the raw pedestrian push-button of the traffic-light intersection and turns it into a clean, held crossing request for the traffic-light controller. It sits directly upstream of that controller: it synchronises and debounces the asynchronous button, and holds a request level until the controller shows red. It drives the "aguarde" (wait) lamp and enforces a cooldown so that one crossing cycle serves one request.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive synchronised cycles a new button level must hold before it is accepted; legal range 1–255.
- COOLDOWN_CYCLES, 8: cycles after red falls during which presses are ignored; 0 means no cooldown; legal range 0–255.
- clk  input  1  system clock; everything updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_raw  input  1  raw push-button, asynchronous, bouncy, active-high.
- red  input  1  red lamp output of the traffic-light controller (registered, synchronous to clk).
- btn  output  1  crossing request to the traffic-light controller, level, registered.
- wait_led  output  1  pedestrian "aguarde" lamp, registered.

## Operation
- Reset, when rst=1 at an edge: btn=0, wait_led=0, state IDLE, synchroniser flops s1=s2=0, debounced level db=0, db_q=0, debounce counter 0, cooldown counter 0. rst overrides every other condition.
- Synchroniser: two flops, s1<=btn_raw and s2<=s1.
- Debounce counter, width 8:
  - If s2==db, the counter is cleared.
  - Else, if the counter equals DEBOUNCE_CYCLES-1, then db<=s2 and the counter is cleared.
  - Else, the counter increments.
- db_q<=db every cycle. The press event is combinational: press = db & ~db_q. Releases generate no event.
- FSM, with outputs registered and assigned on the same edge as the transition:
  - IDLE (btn=0, wait_led=0): press & ~red -> PEND. A press while red=1 is ignored and the state stays IDLE.
  - PEND (btn=1, wait_led=1): red=1 -> SERVE. Otherwise the state holds. Further presses are ignored.
  - SERVE (btn=0, wait_led=0): red=0 -> COOL with the cooldown counter loaded to COOLDOWN_CYCLES; if COOLDOWN_CYCLES=0, go directly to IDLE. Presses are ignored.
  - COOL (btn=0, wait_led=0): the counter decrements each cycle; when it reaches 1 -> IDLE. Presses are ignored and not queued.
- Requests are never queued. At most one request is outstanding at any time.

## Timing
- Press latency: let edge N be the first edge at which s1 captures btn_raw=1 and btn_raw stays high. Then s2=1 after edge N+1, db=1 after edge N+DEBOUNCE_CYCLES+1, and btn=wait_led=1 after edge N+DEBOUNCE_CYCLES+2.
- Glitch rejection: any s2 excursion shorter than DEBOUNCE_CYCLES cycles leaves db unchanged. A bounce clears the counter, and counting restarts from 0.
- Request clear: btn and wait_led fall at the first edge at which red=1 is sampled in PEND. The total btn-high time is unbounded and held until red.
- Cooldown: IDLE is re-entered exactly COOLDOWN_CYCLES edges after the edge that sampled red=0 in SERVE. A press event arriving in the same cycle that the state becomes IDLE is accepted on the following edge only if press is still asserted. Because press is a one-cycle event, such a press is lost unless it occurs at or after IDLE entry.
- Reset mid-operation: all outputs are 0 after the rst edge. If btn_raw is still held high after reset, db re-qualifies from 0, so a new request is raised DEBOUNCE_CYCLES+2 edges after rst falls.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and COOLDOWN_CYCLES=8.
- Reset: rst=1 for 2 cycles with btn_raw=1 and red=0.
  - During reset: btn=0 and wait_led=0.
  - After rst falls, btn=wait_led=1 exactly 6 edges after the first post-reset edge.
- Glitch: btn_raw=1 for 3 cycles, then 0, with red=0 -> btn stays 0 for 20 cycles.
- Bounce: btn_raw toggles every cycle for 6 cycles, then stays 1 -> exactly one rise of btn, 6 edges after the toggling stops.
- Full service:
  - Clean press with red=0 -> btn=1.
  - red driven 1 after 15 cycles -> btn=wait_led=0 at the next edge.
  - red falls -> a press during the 8-cycle cooldown produces no btn; a press issued 9 cycles after red falls raises btn again.
- Press during red: btn_raw pressed cleanly while red=1, released before red falls -> btn and wait_led stay 0 throughout.
- Reset in PEND: rst pulsed for 1 cycle while btn=1 and btn_raw is held at 1 -> btn=0 after the rst edge, then btn=1 again 6 edges later.
